// File: rtl/kernel_bc_start_fifo_ex.sv
// ---------------------------------------------------------------------------
// kernel_bc_start_fifo_ex
//
// Start-token / small-data FIFO placed between a producer and a consumer
// process of the kernel_bc dataflow region. Storage is a shift register of
// DEPTH entries (any depth >= 2). The newest entry always sits at index 0 and
// the oldest (head) entry at index count-1. Control state is held in
// registers so every output except if_dout is registered; if_dout is a
// combinational mux selected by the occupancy count.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   if_din        write data
//   if_write      write request (qualified by if_write_ce)
//   if_write_ce   write clock-enable
//   if_full_n     1 = at least one free entry
//   if_dout       head-of-FIFO data (don't-care while if_empty_n = 0)
//   if_read       read request (qualified by if_read_ce)
//   if_read_ce    read clock-enable
//   if_empty_n    1 = at least one valid entry
//   flush         synchronous empty command, overrides read and write
//   count         current occupancy, 0..DEPTH
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   err_clr       clears the sticky error flags
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module kernel_bc_start_fifo_ex #(
    parameter int DATA_WIDTH    = 1,
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 2,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic                  if_empty_n,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] count_q,    count_d;
    logic             empty_n_q,  empty_n_d;
    logic             full_n_q,   full_n_d;
    logic             afull_q,    afull_d;
    logic             aempty_q,   aempty_d;
    logic             ovf_q,      ovf_d;
    logic             udf_q,      udf_d;

    // Qualified requests and accepted transfers.
    logic wr_req;
    logic rd_req;
    logic wr;
    logic rd;
    logic ovf_set;
    logic udf_set;

    // Head index; wraps to all-ones when count is 0, which matches no entry.
    logic [CNT_W-1:0] head_idx;

    assign wr_req = if_write & if_write_ce;
    assign rd_req = if_read  & if_read_ce;

    // A write at full is rejected even if a read frees a slot the same cycle,
    // because acceptance looks only at the registered full flag.
    assign wr = wr_req & full_n_q;
    assign rd = rd_req & empty_n_q;

    // Rejected requests are errors, except when a flush discards them anyway.
    assign ovf_set = wr_req & ~full_n_q  & ~flush;
    assign udf_set = rd_req & ~empty_n_q & ~flush;

    assign head_idx = count_q - CNT_W'(1);

    // -----------------------------------------------------------------------
    // Storage: shift register, no reset. Contents beyond count are invisible,
    // so a reset only needs to clear the count.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= if_din;
        end
    end

    // Head-of-FIFO read mux.
    always_comb begin
        if_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head_idx == CNT_W'(i)) begin
                if_dout = mem_q[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: occupancy and flags. All flags are derived from count_d so
    // they always agree with the count register on the following cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr && rd) begin
            count_d = count_q;
        end else if (wr) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd) begin
            count_d = count_q - CNT_W'(1);
        end

        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != DEPTH_C);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);

        // A set in the same cycle as err_clr wins over the clear.
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        udf_d = udf_set | (udf_q & ~err_clr);
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign count        = count_q;
    assign if_empty_n   = empty_n_q;
    assign if_full_n    = full_n_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
